// File: rtl/pipe_stage_buf_pkg.sv
// Shared pipeline types for the RV32I stage buffers: handshake bundle, depth limit,
// buffer operation encoding and pointer sizing helper.
package pipe_stage_buf_pkg;

    localparam int PIPE_BUF_MAX_DEPTH = 8;

    typedef struct packed {
        logic valid;
        logic ready;
    } stage_hs_t;

    // Encoded as {push, pop} so it can be cast straight from the two strobes.
    typedef enum logic [1:0] {
        BUF_IDLE = 2'b00,
        BUF_POP  = 2'b01,
        BUF_PUSH = 2'b10,
        BUF_BOTH = 2'b11
    } buf_op_e;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready/data bundle between two pipeline stages; master drives the payload,
// slave answers with ready.
interface pipe_stage_buf_if #(
    parameter int WIDTH = 32
);

    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );

endinterface

// File: rtl/pipe_buf_ptr.sv
// Wrap-around index counter for the stage buffer; counts 0..DEPTH-1 so that
// non-power-of-two depths wrap correctly. clr takes priority over inc.
module pipe_buf_ptr
    import pipe_stage_buf_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = ptr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clr,
    output logic [PW-1:0] ptr
);

    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic valid/ready FIFO between RV32I pipeline stages with synchronous flush.
// Define PIPE_STAGE_BUF_BYPASS_EN for zero-latency passthrough when empty.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = ptr_width(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    pipe_stage_buf_if.slave        in_bus,
    pipe_stage_buf_if.master       out_bus,
    output logic [CW-1:0]          count
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    if (DEPTH < 1 || DEPTH > PIPE_BUF_MAX_DEPTH) begin : g_bad_depth
        $error("pipe_stage_buf: DEPTH must be within 1..8");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] head_data;
    stage_hs_t        in_hs;
    stage_hs_t        out_hs;
    logic             bypass;
    logic             push;
    logic             pop;
    buf_op_e          op;

`ifdef PIPE_STAGE_BUF_BYPASS_EN
    assign bypass = (count_q == '0) & in_bus.valid & out_bus.ready & ~flush;
`else
    assign bypass = 1'b0;
`endif

    // in_ready is derived from registered occupancy only, never from out_ready.
    always_comb begin
        in_hs.valid  = in_bus.valid;
        in_hs.ready  = (count_q != FULL);
        out_hs.valid = (count_q != '0) | bypass;
        out_hs.ready = out_bus.ready;
        push         = in_hs.valid & in_hs.ready & ~flush & ~bypass;
        pop          = out_hs.valid & out_hs.ready & ~bypass;
        op           = buf_op_e'({push, pop});
    end

    always_comb begin
        head_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_ptr == PW'(i)) begin
                head_data = mem[i];
            end
        end
    end

    assign in_bus.ready  = in_hs.ready;
    assign out_bus.valid = out_hs.valid;
    assign out_bus.data  = bypass ? in_bus.data : head_data;
    assign count         = count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_ptr == PW'(i)) begin
                    mem[i] <= in_bus.data;
                end
            end
        end
    end

    // Flush clears occupancy but leaves mem untouched; stale entries are unreachable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (flush) begin
            count_q <= '0;
        end else begin
            case (op)
                BUF_PUSH: count_q <= count_q + 1'b1;
                BUF_POP:  count_q <= count_q - 1'b1;
                default:  count_q <= count_q;
            endcase
        end
    end

    pipe_buf_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (push),
        .clr (flush),
        .ptr (wr_ptr)
    );

    pipe_buf_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (pop),
        .clr (flush),
        .ptr (rd_ptr)
    );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: DEPTH=2 instance for reset/fill/flush/bypass/
// mid-stream reset, DEPTH=3 instance for pointer wrap-around streaming.
module tb_pipe_stage_buf;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush2;
    logic       flush3;
    logic [1:0] count2;
    logic [1:0] count3;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    pipe_stage_buf_if #(.WIDTH(32)) in2 ();
    pipe_stage_buf_if #(.WIDTH(32)) out2 ();
    pipe_stage_buf_if #(.WIDTH(32)) in3 ();
    pipe_stage_buf_if #(.WIDTH(32)) out3 ();

    pipe_stage_buf #(.WIDTH(32), .DEPTH(2)) dut2 (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush2),
        .in_bus (in2),
        .out_bus(out2),
        .count  (count2)
    );

    pipe_stage_buf #(.WIDTH(32), .DEPTH(3)) dut3 (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush3),
        .in_bus (in3),
        .out_bus(out3),
        .count  (count3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        checks++; if (out2.valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out2.valid); end
        checks++; if (in2.ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in2.ready); end
        checks++; if (count2 !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count2); end
        checks++; if (out2.data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out2.data); end
        checks++; if (count3 !== 2'd0) begin errors++; $display("FAIL reset_count_d3: got %0d want 0", count3); end
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_fill_overflow();
        out2.ready = 1'b0;
        in2.valid  = 1'b1;
        in2.data   = 32'hA;
        step();
        in2.data = 32'hB;
        step();
        @(negedge clk);
        checks++; if (count2 !== 2'd2) begin errors++; $display("FAIL fill_count: got %0d want 2", count2); end
        checks++; if (in2.ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b want 0", in2.ready); end
        checks++; if (out2.data !== 32'hA) begin errors++; $display("FAIL fill_head: got %h want a", out2.data); end
        in2.data = 32'hC;
        step();
        @(negedge clk);
        checks++; if (count2 !== 2'd2) begin errors++; $display("FAIL overflow_count: got %0d want 2", count2); end
        checks++; if (out2.data !== 32'hA) begin errors++; $display("FAIL overflow_head: got %h want a", out2.data); end
        in2.valid  = 1'b0;
        out2.ready = 1'b1;
        #1;
        checks++; if (in2.ready !== 1'b0) begin errors++; $display("FAIL pop_cycle_in_ready: got %b want 0", in2.ready); end
        checks++; if (out2.data !== 32'hA) begin errors++; $display("FAIL drain_first: got %h want a", out2.data); end
        step();
        checks++; if (in2.ready !== 1'b1) begin errors++; $display("FAIL after_pop_in_ready: got %b want 1", in2.ready); end
        checks++; if (out2.data !== 32'hB) begin errors++; $display("FAIL drain_second: got %h want b", out2.data); end
        checks++; if (count2 !== 2'd1) begin errors++; $display("FAIL drain_count: got %0d want 1", count2); end
        step();
        for (int i = 0; i < 2; i++) begin
            checks++; if (out2.valid !== 1'b0) begin errors++; $display("FAIL refused_never_appears: got valid=%b data=%h want valid=0", out2.valid, out2.data); end
            step();
        end
        out2.ready = 1'b0;
    endtask

    task automatic test_wrap();
        int   next_in  = 1;
        int   next_out = 1;
        int   exp_cnt  = 0;
        logic byp;
        logic push_m;
        logic pop_m;
        for (int cyc = 0; cyc < 80 && next_out <= 10; cyc++) begin
            in3.valid  = (next_in <= 10);
            in3.data   = 32'(next_in);
            out3.ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            @(negedge clk);
            byp = 1'b0;
`ifdef PIPE_STAGE_BUF_BYPASS_EN
            byp = (exp_cnt == 0) && in3.valid && out3.ready;
`endif
            push_m = in3.valid && (exp_cnt != 3) && !byp;
            pop_m  = out3.ready && ((exp_cnt != 0) || byp);
            checks++; if (count3 !== 2'(exp_cnt)) begin errors++; $display("FAIL wrap_count c%0d: got %0d want %0d", cyc, count3, exp_cnt); end
            checks++; if (in3.ready !== (exp_cnt != 3)) begin errors++; $display("FAIL wrap_in_ready c%0d: got %b want %b", cyc, in3.ready, exp_cnt != 3); end
            checks++; if (out3.valid !== ((exp_cnt != 0) || byp)) begin errors++; $display("FAIL wrap_out_valid c%0d: got %b want %b", cyc, out3.valid, (exp_cnt != 0) || byp); end
            if (pop_m) begin
                checks++; if (out3.data !== 32'(next_out)) begin errors++; $display("FAIL wrap_order c%0d: got %0d want %0d", cyc, out3.data, next_out); end
                next_out++;
            end
            if (byp || push_m) next_in++;
            if (push_m) exp_cnt++;
            if (pop_m && !byp) exp_cnt--;
            @(posedge clk);
            #1;
        end
        in3.valid  = 1'b0;
        out3.ready = 1'b0;
        checks++; if (next_out !== 11) begin errors++; $display("FAIL wrap_complete: got %0d outputs want 10", next_out - 1); end
    endtask

    task automatic test_flush();
        out2.ready = 1'b0;
        in2.valid  = 1'b1;
        in2.data   = 32'h11;
        step();
        in2.data = 32'h22;
        step();
        checks++; if (count2 !== 2'd2) begin errors++; $display("FAIL flush_precount: got %0d want 2", count2); end
        flush2   = 1'b1;
        in2.data = 32'hDD;
        step();
        flush2    = 1'b0;
        in2.valid = 1'b0;
        checks++; if (count2 !== 2'd0) begin errors++; $display("FAIL flush_count: got %0d want 0", count2); end
        checks++; if (out2.valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b want 0", out2.valid); end
        checks++; if (in2.ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b want 1", in2.ready); end
        out2.ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (out2.valid !== 1'b0) begin errors++; $display("FAIL flush_squashed: got valid=%b data=%h want valid=0", out2.valid, out2.data); end
        end
        out2.ready = 1'b0;
    endtask

    task automatic test_bypass();
        in2.valid  = 1'b1;
        in2.data   = 32'h55;
        out2.ready = 1'b1;
        #1;
`ifdef PIPE_STAGE_BUF_BYPASS_EN
        checks++; if (out2.valid !== 1'b1) begin errors++; $display("FAIL bypass_valid: got %b want 1", out2.valid); end
        checks++; if (out2.data !== 32'h55) begin errors++; $display("FAIL bypass_data: got %h want 55", out2.data); end
        checks++; if (count2 !== 2'd0) begin errors++; $display("FAIL bypass_count: got %0d want 0", count2); end
        step();
        in2.valid = 1'b0;
        checks++; if (count2 !== 2'd0) begin errors++; $display("FAIL bypass_not_stored: got %0d want 0", count2); end
        checks++; if (out2.valid !== 1'b0) begin errors++; $display("FAIL bypass_after_valid: got %b want 0", out2.valid); end
`else
        checks++; if (out2.valid !== 1'b0) begin errors++; $display("FAIL nobypass_valid: got %b want 0", out2.valid); end
        step();
        in2.valid = 1'b0;
        checks++; if (out2.valid !== 1'b1) begin errors++; $display("FAIL nobypass_late_valid: got %b want 1", out2.valid); end
        checks++; if (out2.data !== 32'h55) begin errors++; $display("FAIL nobypass_late_data: got %h want 55", out2.data); end
        checks++; if (count2 !== 2'd1) begin errors++; $display("FAIL nobypass_count: got %0d want 1", count2); end
        step();
        checks++; if (count2 !== 2'd0) begin errors++; $display("FAIL nobypass_drained: got %0d want 0", count2); end
`endif
        out2.ready = 1'b0;
    endtask

    task automatic test_midstream_reset();
        int seen = 0;
        out2.ready = 1'b0;
        in2.valid  = 1'b1;
        in2.data   = 32'h66;
        step();
        in2.valid = 1'b0;
        checks++; if (count2 !== 2'd1) begin errors++; $display("FAIL midrst_precount: got %0d want 1", count2); end
        rst = 1'b0;
        #1;
        checks++; if (count2 !== 2'd0) begin errors++; $display("FAIL midrst_count: got %0d want 0", count2); end
        checks++; if (out2.valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b want 0", out2.valid); end
        checks++; if (out2.data !== 32'h0) begin errors++; $display("FAIL midrst_out_data: got %h want 0", out2.data); end
        checks++; if (in2.ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b want 1", in2.ready); end
        #4 rst = 1'b1;
        step();
        out2.ready = 1'b1;
        in2.valid  = 1'b1;
        in2.data   = 32'h77;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out2.valid && out2.ready) begin
                seen++;
                if (seen == 1) begin
                    checks++; if (out2.data !== 32'h77) begin errors++; $display("FAIL midrst_first_out: got %h want 77", out2.data); end
                end
            end
            step();
            in2.valid = 1'b0;
        end
        checks++; if (seen !== 1) begin errors++; $display("FAIL midrst_out_total: got %0d want 1", seen); end
        out2.ready = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        flush2     = 1'b0;
        flush3     = 1'b0;
        in2.valid  = 1'b0;
        in2.data   = '0;
        out2.ready = 1'b0;
        in3.valid  = 1'b0;
        in3.data   = '0;
        out3.ready = 1'b0;
        test_reset();
        test_fill_overflow();
        test_wrap();
        test_flush();
        test_bypass();
        test_midstream_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] simulation timeout");
    end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Parametrised elastic inter-stage buffer for the RV32I pipeline. It replaces the bare stage registers between fetch, decode, execute, memory and writeback.
- Holds up to DEPTH payloads of WIDTH bits, for example a packed stage struct, in a circular FIFO.
- Uses valid/ready handshakes on both sides, so a stalled stage can back-pressure the one before it without losing data.
- Synchronous flush squashes all buffered entries on a branch redirect.

Parameters:
WIDTH, 32, payload width in bits; set to $bits(stage struct) at instantiation.
DEPTH, 2, number of entries; legal range 1..8, any integer (power of two not required).

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; one clock domain, asynchronous, active-low
flush  in  1  synchronous squash of all entries
in_valid  in  1  upstream has a payload
in_ready  out  1  buffer can accept a payload
in_data  in  WIDTH  upstream payload
out_valid  out  1  head entry valid
out_ready  in  1  downstream consumes the head
out_data  out  WIDTH  head payload
count  out  $clog2(DEPTH+1)  number of occupied entries

Behaviour:
- Handshakes:
  - push = in_valid & in_ready & !flush.
  - pop = out_valid & out_ready.
- Storage and pointers:
  - mem[DEPTH], wr_ptr, rd_ptr, count, all registered.
  - Pointers wrap from DEPTH-1 to 0 (explicit compare, not modulo 2^n).
- Outputs:
  - in_ready = (count != DEPTH). It is a function of registered state only; there is no combinational path from out_ready.
  - out_valid = (count != 0).
  - out_data = mem[rd_ptr].
- Latency: 1 cycle minimum. A payload pushed at edge N is visible on out_data after edge N.
- Full buffer: push is refused because in_ready=0. A simultaneous pop frees a slot, but in_ready only rises the next cycle.
- Empty buffer: pop is impossible. A push goes to mem[wr_ptr], and count becomes 1.
- Simultaneous push and pop (0<count<DEPTH): both pointers advance and count is unchanged.
- Flush:
  - At the next edge, count=0 and wr_ptr=rd_ptr=0. mem contents are left unchanged.
  - An in_data presented in the flush cycle is discarded.
  - A pop in the flush cycle is legal; the downstream owns that instruction.
  - Flush has priority over push.
- Reset (rst=0, asynchronous):
  - count=0, pointers=0, every mem entry=0.
  - Outputs take these values immediately, without waiting for a clock edge: out_valid=0, in_ready=1, out_data=0, count=0.
  - Reset in mid-operation drops all entries, with no partial state.
- DEPTH=1 degenerates to a half-throughput register: in_ready=!out_valid.
- Payload ordering is strict FIFO. The buffer never reorders, duplicates or drops a pushed entry, except on flush.

Optional Feature:
Macro PIPE_STAGE_BUF_BYPASS_EN.
- Defined: when count==0, in_valid=1, out_ready=1 and flush=0:
  - out_valid=1 and out_data=in_data combinationally in the same cycle.
  - The payload is not written, and count stays 0.
  - This gives zero-latency passthrough for an unstalled pipeline.
- Undefined: out_* come from storage only, so minimum latency is 1 cycle.
- in_ready never depends on out_ready in either build.

Decomposition:
- Add to the shared rv32i_types package:
  - typedef stage_hs_t {valid, ready}, for handshake bundles between stages.
  - localparam PIPE_BUF_MAX_DEPTH = 8.
- Stage structs remain in that package and are passed as WIDTH via $bits.
- One sub-module, pipe_buf_ptr: a wrap-around pointer counter parametrised by DEPTH, with inc and clr inputs. It is instantiated twice, for rd and wr.

Test Plan:
1. Reset, WIDTH=32, DEPTH=2: drive rst=0 between clock edges -> out_valid=0, in_ready=1, count=0, out_data=0 immediately, before the next edge.
2. Fill and overflow, out_ready=0: push 0xA then 0xB -> count=2, in_ready=0. Present 0xC -> refused.
   - Then set out_ready=1 -> out_data 0xA, then 0xB.
   - in_ready returns to 1 one cycle after the first pop.
   - 0xC never appears unless re-presented.
3. Wrap-around, DEPTH=3: stream values 1..10 with out_ready toggling 1,0,0,1 repeating -> output sequence is exactly 1..10, count stays ≤3, and pointers wrap 2->0.
4. Flush: count=2 holding 0x11, 0x22; assert flush with in_valid=1, in_data=0xDD -> next cycle count=0, out_valid=0. 0x11, 0x22 and 0xDD never appear.
5. Bypass: with macro defined, empty buffer, in_valid=1, in_data=0x55, out_ready=1 -> out_valid=1, out_data=0x55 in the same cycle, count stays 0.
   - With macro undefined -> 0x55 appears one cycle later with count=1.
6. Mid-stream reset: count=1, pull rst low for half a cycle -> outputs reset asynchronously. After release, a push of 0x77 is the first and only output.
